// File: rtl/datapath_ctrl_if.sv
// Command, response and datapath-control signals of the datapath sequencing controller.
// master = instruction source / response consumer / datapath; slave = the controller.
interface datapath_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_instr;

    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] resp_data;
    logic       resp_carry;

    logic       dp_mux_sel;
    logic       dp_load;
    logic [1:0] dp_alu_sel;
    logic [3:0] dp_mux_data;
    logic [3:0] dp_alu_data;
    logic [3:0] dp_reg_out;
    logic       dp_carry_out;

    modport master (
        output in_valid, in_instr, resp_ready, dp_reg_out, dp_carry_out,
        input  in_ready, resp_valid, resp_data, resp_carry,
        input  dp_mux_sel, dp_load, dp_alu_sel, dp_mux_data, dp_alu_data
    );

    modport slave (
        input  in_valid, in_instr, resp_ready, dp_reg_out, dp_carry_out,
        output in_ready, resp_valid, resp_data, resp_carry,
        output dp_mux_sel, dp_load, dp_alu_sel, dp_mux_data, dp_alu_data
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Sequencing controller: expands each instruction into rep+1 datapath cycles, then returns acc/carry.
// Build option DPCTRL_CARRY_STICKY_EN: ADD ORs into the carry flag instead of overwriting it.
module datapath_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    datapath_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rep;
        logic [3:0] imm;
    } instr_t;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_CLRC = 3'b010;
    localparam logic [1:0] ALU_ADD = 2'b11;

    instr_t     instr;
    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] imm_q, imm_d;
    logic       carry_q, carry_d;

    logic       in_ready;
    logic       resp_valid;
    logic       mux_sel;
    logic       load;
    logic [1:0] alu_sel;
    logic [3:0] mux_data;
    logic [3:0] alu_data;

    assign instr = bus.in_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            imm_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            imm_q   <= imm_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        imm_d      = imm_q;
        carry_d    = carry_q;
        in_ready   = 1'b0;
        resp_valid = 1'b0;
        mux_sel    = 1'b0;
        load       = 1'b0;
        alu_sel    = 2'b00;
        mux_data   = 4'h0;
        alu_data   = 4'h0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    op_d    = instr.op;
                    cnt_d   = instr.rep;
                    imm_d   = instr.imm;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q[2]) begin
                    mux_sel  = 1'b1;
                    load     = 1'b1;
                    alu_sel  = op_q[1:0];
                    alu_data = imm_q;
                    if (op_q[1:0] == ALU_ADD) begin
`ifdef DPCTRL_CARRY_STICKY_EN
                        carry_d = carry_q | bus.dp_carry_out;
`else
                        carry_d = bus.dp_carry_out;
`endif
                    end
                end else if (op_q == OP_LOAD) begin
                    load     = 1'b1;
                    mux_data = imm_q;
                end else if (op_q == OP_CLRC) begin
                    carry_d = 1'b0;
                end
                // NOP and the reserved opcode fall through with all controls idle
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // No loads happen outside EXEC, so the register (and thus resp_data) holds under backpressure.
    assign bus.in_ready    = in_ready;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_data   = bus.dp_reg_out;
    assign bus.resp_carry  = carry_q;
    assign bus.dp_mux_sel  = mux_sel;
    assign bus.dp_load     = load;
    assign bus.dp_alu_sel  = alu_sel;
    assign bus.dp_mux_data = mux_data;
    assign bus.dp_alu_data = alu_data;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl with a behavioural 4-bit datapath (mux, register, ALU) attached.
module tb_datapath_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    datapath_ctrl_if dif ();

    datapath_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    // Datapath model: register has no reset, ALU carry only meaningful for ADD.
    logic [3:0] dp_reg;
    logic [4:0] alu_res;

    always_comb begin
        alu_res = 5'd0;
        case (dif.dp_alu_sel)
            2'b00:   alu_res = {1'b0, dp_reg & dif.dp_alu_data};
            2'b01:   alu_res = {1'b0, dp_reg | dif.dp_alu_data};
            2'b10:   alu_res = {1'b0, dp_reg ^ dif.dp_alu_data};
            default: alu_res = {1'b0, dp_reg} + {1'b0, dif.dp_alu_data};
        endcase
    end

    always_ff @(posedge clk) begin
        if (dif.dp_load) dp_reg <= dif.dp_mux_sel ? alu_res[3:0] : dif.dp_mux_data;
    end

    assign dif.dp_reg_out   = dp_reg;
    assign dif.dp_carry_out = alu_res[4];

    function automatic logic [9:0] ins(input logic [2:0] op, input logic [2:0] rep, input logic [3:0] imm);
        return {op, rep, imm};
    endfunction

    function automatic logic [11:0] dp_bundle();
        return {dif.dp_mux_sel, dif.dp_load, dif.dp_alu_sel, dif.dp_mux_data, dif.dp_alu_data};
    endfunction

    // Issues one instruction from IDLE, observes it to the response and acknowledges it.
    task automatic run_instr(input logic [9:0] instr, output int loads, output int cyc,
                             output logic [3:0] data, output logic c, output logic to,
                             output logic [2:0] sel, output logic rdy, output logic [11:0] dp_resp);
        int n;
        loads = 0; cyc = 0; data = 'x; c = 'x; to = 1'b1; sel = 'x; rdy = 'x; dp_resp = 'x; n = 0;
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.in_instr = instr;
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                sel = {dif.dp_mux_sel, dif.dp_alu_sel};
                rdy = dif.in_ready;
            end
            if (dif.resp_valid) begin
                to = 1'b0; cyc = n - 1; data = dif.resp_data; c = dif.resp_carry; dp_resp = dp_bundle();
                break;
            end
            if (dif.dp_load) loads++;
        end
        dif.resp_ready = 1'b1;
        @(posedge clk);
        #1 dif.resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (dif.in_ready !== 1'b1 || dif.resp_valid !== 1'b0 || dif.resp_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: rdy=%b rv=%b c=%b want 1 0 0", dif.in_ready, dif.resp_valid, dif.resp_carry);
        end
        checks++;
        if (dp_bundle() !== 12'h000) begin
            errors++;
            $display("FAIL reset_dp: got %h want 000", dp_bundle());
        end
    endtask

    task automatic test_load;
        int loads, cyc; logic [3:0] d; logic c, to, rdy; logic [2:0] sel; logic [11:0] dpr;
        run_instr(ins(3'b001, 3'd0, 4'h5), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (to !== 1'b0 || cyc != 1) begin errors++; $display("FAIL load_lat: to=%b cyc=%0d want 0 1", to, cyc); end
        checks++;
        if (d !== 4'h5 || c !== 1'b0) begin errors++; $display("FAIL load_data: %h/%b want 5/0", d, c); end
        checks++;
        if (loads != 1) begin errors++; $display("FAIL load_pulses: %0d want 1", loads); end
        checks++;
        if (rdy !== 1'b0 || dpr !== 12'h000) begin errors++; $display("FAIL load_idle: rdy=%b dp=%h want 0 000", rdy, dpr); end
    endtask

    task automatic test_accumulate;
        int loads, cyc; logic [3:0] d; logic c, to, rdy; logic [2:0] sel; logic [11:0] dpr;
        run_instr(ins(3'b001, 3'd0, 4'h0), loads, cyc, d, c, to, sel, rdy, dpr);
        run_instr(ins(3'b111, 3'd4, 4'h3), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (to !== 1'b0 || cyc != 5) begin errors++; $display("FAIL acc_lat: to=%b cyc=%0d want 0 5", to, cyc); end
        checks++;
        if (loads != 5) begin errors++; $display("FAIL acc_pulses: %0d want 5", loads); end
        checks++;
        if (d !== 4'hF || c !== 1'b0) begin errors++; $display("FAIL acc_data: %h/%b want F/0", d, c); end
    endtask

    task automatic test_add_carry;
        int loads, cyc; logic [3:0] d; logic c, to, rdy; logic [2:0] sel; logic [11:0] dpr;
        run_instr(ins(3'b001, 3'd0, 4'h9), loads, cyc, d, c, to, sel, rdy, dpr);
        run_instr(ins(3'b111, 3'd0, 4'h8), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (to !== 1'b0 || d !== 4'h1 || c !== 1'b1) begin errors++; $display("FAIL add_wrap: %h/%b want 1/1", d, c); end
        checks++;
        if (sel !== 3'b111) begin errors++; $display("FAIL add_ctrl: mux/alu=%b want 111", sel); end
    endtask

    task automatic test_carry_mode;
        int loads, cyc; logic [3:0] d; logic c, to, rdy; logic [2:0] sel; logic [11:0] dpr;
        logic exp_c;
`ifdef DPCTRL_CARRY_STICKY_EN
        exp_c = 1'b1;
`else
        exp_c = 1'b0;
`endif
        run_instr(ins(3'b001, 3'd0, 4'h1), loads, cyc, d, c, to, sel, rdy, dpr);
        run_instr(ins(3'b111, 3'd0, 4'h1), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (to !== 1'b0 || d !== 4'h2 || c !== exp_c) begin errors++; $display("FAIL carry_mode: %h/%b want 2/%b", d, c, exp_c); end
        run_instr(ins(3'b010, 3'd0, 4'h0), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (to !== 1'b0 || d !== 4'h2 || c !== 1'b0 || loads != 0) begin
            errors++; $display("FAIL clrc: %h/%b loads=%0d want 2/0 0", d, c, loads);
        end
    endtask

    task automatic test_logic_ops;
        int loads, cyc; logic [3:0] d; logic c, to, rdy; logic [2:0] sel; logic [11:0] dpr;
        run_instr(ins(3'b001, 3'd0, 4'hC), loads, cyc, d, c, to, sel, rdy, dpr);
        run_instr(ins(3'b100, 3'd0, 4'hA), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (d !== 4'h8) begin errors++; $display("FAIL and_op: %h want 8", d); end
        run_instr(ins(3'b101, 3'd0, 4'h3), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (d !== 4'hB) begin errors++; $display("FAIL or_op: %h want B", d); end
        run_instr(ins(3'b110, 3'd0, 4'hF), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (d !== 4'h4 || c !== 1'b0 || sel !== 3'b110) begin
            errors++; $display("FAIL xor_op: %h/%b sel=%b want 4/0 110", d, c, sel);
        end
    endtask

    task automatic test_nop;
        int loads, cyc; logic [3:0] d; logic c, to, rdy; logic [2:0] sel; logic [11:0] dpr;
        run_instr(ins(3'b000, 3'd2, 4'h7), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (to !== 1'b0 || cyc != 3 || loads != 0 || d !== 4'h4) begin
            errors++; $display("FAIL nop: cyc=%0d loads=%0d d=%h want 3 0 4", cyc, loads, d);
        end
        run_instr(ins(3'b011, 3'd1, 4'h9), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (to !== 1'b0 || cyc != 2 || loads != 0 || d !== 4'h4) begin
            errors++; $display("FAIL reserved: cyc=%0d loads=%0d d=%h want 2 0 4", cyc, loads, d);
        end
    endtask

    task automatic test_back_to_back;
        bit seen = 0;
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.in_instr = ins(3'b001, 3'd0, 4'h7);
        @(posedge clk);
        #1 dif.in_instr = ins(3'b001, 3'd0, 4'hA);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (dif.resp_valid) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_resp: no resp_valid within 10 cycles"); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dif.resp_valid !== 1'b1 || dif.resp_data !== 4'h7 || dif.in_ready !== 1'b0 || dif.dp_load !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: rv=%b d=%h rdy=%b ld=%b want 1 7 0 0", i, dif.resp_valid, dif.resp_data, dif.in_ready, dif.dp_load);
            end
            @(negedge clk);
        end
        dif.resp_ready = 1'b1;
        @(posedge clk);
        #1 dif.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.in_ready !== 1'b1 || dif.resp_valid !== 1'b0 || dif.dp_load !== 1'b0) begin
            errors++; $display("FAIL bp_idle: rdy=%b rv=%b ld=%b want 1 0 0", dif.in_ready, dif.resp_valid, dif.dp_load);
        end
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.dp_load !== 1'b1 || dif.dp_mux_data !== 4'hA || dif.dp_mux_sel !== 1'b0) begin
            errors++; $display("FAIL bp_next: ld=%b md=%h ms=%b want 1 A 0", dif.dp_load, dif.dp_mux_data, dif.dp_mux_sel);
        end
        @(negedge clk);
        checks++;
        if (dif.resp_valid !== 1'b1 || dif.resp_data !== 4'hA) begin
            errors++; $display("FAIL bp_next_resp: rv=%b d=%h want 1 A", dif.resp_valid, dif.resp_data);
        end
        dif.resp_ready = 1'b1;
        @(posedge clk);
        #1 dif.resp_ready = 1'b0;
    endtask

    task automatic test_abort;
        int loads, cyc; logic [3:0] d; logic c, to, rdy; logic [2:0] sel; logic [11:0] dpr;
        bit got = 0;
        run_instr(ins(3'b001, 3'd0, 4'hF), loads, cyc, d, c, to, sel, rdy, dpr);
        run_instr(ins(3'b111, 3'd0, 4'h1), loads, cyc, d, c, to, sel, rdy, dpr);
        checks++;
        if (to !== 1'b0 || d !== 4'h0 || c !== 1'b1) begin errors++; $display("FAIL abort_setup: %h/%b want 0/1", d, c); end
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.in_instr = ins(3'b000, 3'd7, 4'h0);
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dif.in_ready !== 1'b0) begin errors++; $display("FAIL abort_exec: rdy=%b want 0", dif.in_ready); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dif.in_ready !== 1'b1 || dif.resp_valid !== 1'b0 || dif.resp_carry !== 1'b0 || dp_bundle() !== 12'h000) begin
            errors++;
            $display("FAIL abort_reset: rdy=%b rv=%b c=%b dp=%h want 1 0 0 000", dif.in_ready, dif.resp_valid, dif.resp_carry, dp_bundle());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dif.resp_valid !== 1'b0 || dif.in_ready !== 1'b1 || dp_bundle() !== 12'h000) got = 1;
        end
        checks++;
        if (got) begin errors++; $display("FAIL abort_after: activity seen after reset release, want idle"); end
    endtask

    initial begin
        rst_n          = 1'b0;
        dif.in_valid   = 1'b0;
        dif.in_instr   = '0;
        dif.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_load;
        test_accumulate;
        test_add_carry;
        test_carry_mode;
        test_logic_ops;
        test_nop;
        test_back_to_back;
        test_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

- Sequencing controller that drives the 4-bit datapath (input mux, accumulator register, ALU) from the command side.
- Accepts instructions over a valid/ready handshake and expands each into one or more datapath cycles, driving mux select, register load, ALU select and operand data.
- Returns the resulting accumulator value and a carry flag over a valid/ready response handshake.
- Sits between the instruction source and the datapath.

## Interface
Parameters: none (datapath width fixed at 4).

Clock and reset (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset

Instruction handshake:
- in_valid  in  1  instruction valid
- in_ready  out  1  controller can accept; high only in IDLE
- in_instr  in  10  {op[9:7], rep[6:4], imm[3:0]}

Response handshake:
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  4  accumulator value, equal to dp_reg_out
- resp_carry  out  1  carry flag

Datapath side:
- dp_mux_sel  out  1  0 = dp_mux_data, 1 = ALU output
- dp_load  out  1  register load enable
- dp_alu_sel  out  2  00 AND, 01 OR, 10 XOR, 11 ADD
- dp_mux_data  out  4  immediate into the mux
- dp_alu_data  out  4  ALU b operand
- dp_reg_out  in  4  register value
- dp_carry_out  in  1  ALU carry

## Operation
- **Opcodes:**
  - 000 NOP: no load.
  - 001 LOAD: mux_sel=0, mux_data=imm, load=1.
  - 010 CLRC: clear carry flag, no load.
  - 011: reserved, executes as NOP.
  - 1xx ALU: mux_sel=1, alu_sel=op[1:0], alu_data=imm, load=1.
- **FSM states:** IDLE, EXEC, RESP.
  - IDLE: in_ready=1. On in_valid, latch op, imm and rep into the counter, then go to EXEC.
  - EXEC: drive the opcode's datapath controls for exactly rep+1 cycles. When the counter is 0, go to RESP; otherwise decrement.
  - RESP: resp_valid=1, resp_data=dp_reg_out, resp_carry=carry flag. Hold until resp_ready, then go to IDLE.
- **Carry flag:**
  - Updated only on EXEC cycles of ADD (op=111), from dp_carry_out in that cycle.
  - Cleared by CLRC, which takes effect on its first EXEC cycle.
- **Outside EXEC:** dp_load, dp_mux_sel, dp_alu_sel, dp_mux_data and dp_alu_data are all 0.
- **Datapath register:** it has no reset. resp_data is undefined until the first LOAD completes after reset.
- **Wrap-around:** ADD wraps modulo 16; the carry reflects each iteration.

## Timing
- **Reset values:** in_ready=1 (IDLE), resp_valid=0, resp_data follows dp_reg_out, resp_carry=0, all dp_* outputs = 0, carry flag=0.
- **rst_n assertion mid-operation:** immediately forces IDLE and the reset values above. dp_load drops combinationally-asynchronously with the state. No response is produced for the aborted instruction.
- **Latency:** accepting edge T. EXEC occupies cycles T..T+rep. resp_valid rises at T+rep+1 with the updated register value.
- **Backpressure:** resp_valid, resp_data and resp_carry are stable while resp_ready=0.
- **Throughput:** in_ready is low in EXEC and RESP; in_valid in those states is ignored. At best, one instruction completes every rep+3 cycles (accept, EXEC, RESP with resp_ready=1, IDLE).
- **Simultaneous events:** resp_ready and in_valid high together in RESP do not accept; acceptance occurs only in IDLE.

## Configuration
- DPCTRL_CARRY_STICKY_EN defined: ADD ORs dp_carry_out into the flag. The flag stays set until CLRC or reset.
- DPCTRL_CARRY_STICKY_EN undefined: ADD overwrites the flag with dp_carry_out. The flag holds the carry of the last ADD iteration.

## Test plan
1. Reset; LOAD imm=0x5 rep=0 -> resp_valid one cycle after accept, resp_data=0x5, resp_carry=0; dp_load high exactly 1 cycle.
2. LOAD 0x9, then ADD imm=0x8 -> resp_data=0x1, resp_carry=1; dp_alu_sel=11, dp_mux_sel=1 during EXEC.
3. LOAD 0x0, then ADD imm=0x3 rep=4 -> dp_load high 5 consecutive cycles, resp_valid 5 cycles after accept, resp_data=0xF, carry=0.
4. After test 2, LOAD 0x1 then ADD 0x1 -> resp_data=0x2; carry=1 with DPCTRL_CARRY_STICKY_EN, 0 without. CLRC -> carry=0.
5. Hold resp_ready low 3 cycles with in_valid high -> response fields stable, in_ready=0, no instruction accepted. After resp_ready, the next instruction is accepted in IDLE.
6. Start NOP rep=7; assert rst_n low on the 3rd EXEC cycle -> no response; after release in_ready=1, carry=0, all dp_* = 0.
